// File: rtl/mem_port_arbiter.sv
// Shares one single-port synchronous RAM between instruction fetch and load/store.
// Latency: req before edge E -> ack and mem_* on the port after E -> rvalid one cycle later.
// Backpressure: requesters hold req and payload until their ack; load/store wins, and a held ls_lock keeps fetch off.
//
// Ports:
//   clk, Rst                       clock, async active-low reset
//   if_req/if_addr -> if_ack       fetch request, one-cycle grant pulse
//   if_rvalid/if_rdata             fetched word qualifier, pass-through of mem_rdata
//   ls_req/ls_we/ls_addr/ls_wdata/ls_lock -> ls_ack   load/store request, grant pulse
//   ls_rvalid/ls_rdata             load data qualifier, pass-through of mem_rdata
//   mem_en/mem_we/mem_addr/mem_wdata/mem_rdata        RAM port
//   locked                         high while an atomic sequence owns the port
module mem_port_arbiter #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              Rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ack,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              ls_req,
    input  logic              ls_we,
    input  logic [ADDR_W-1:0] ls_addr,
    input  logic [DATA_W-1:0] ls_wdata,
    input  logic              ls_lock,
    output logic              ls_ack,
    output logic              ls_rvalid,
    output logic [DATA_W-1:0] ls_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              locked
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_OPEN   = 2'd1;
    localparam logic [1:0] ST_LOCKED = 2'd2;

    logic [1:0]        state_q, state_d;
    logic              if_ack_q, if_ack_d;
    logic              ls_ack_q, ls_ack_d;
    logic              if_rvalid_q, if_rvalid_d;
    logic              ls_rvalid_q, ls_rvalid_d;
    logic              mem_en_q, mem_en_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;

    logic lock_hold;
    logic ls_elig;
    logic if_elig;

    always_comb begin
        // Lock is released at the first edge where ls_lock is seen low, and
        // fetch may be granted at that very edge.
        lock_hold = (state_q == ST_LOCKED) && ls_lock;
        // A requester whose ack is high right now is being served this cycle;
        // its still-high req must not win a second time.
        ls_elig   = ls_req && !ls_ack_q;
        if_elig   = if_req && !if_ack_q && !lock_hold;

        state_d     = ST_IDLE;
        if_ack_d    = 1'b0;
        ls_ack_d    = 1'b0;
        mem_en_d    = 1'b0;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;

        // The access on the port now is sampled by the RAM at the next edge,
        // so its data arrives one cycle after the ack.
        if_rvalid_d = if_ack_q;
        ls_rvalid_d = ls_ack_q && !mem_we_q;

        if (ls_elig) begin
            ls_ack_d    = 1'b1;
            mem_en_d    = 1'b1;
            mem_we_d    = ls_we;
            mem_addr_d  = ls_addr;
            mem_wdata_d = ls_wdata;
            state_d     = ls_lock ? ST_LOCKED : ST_OPEN;
        end else if (if_elig) begin
            if_ack_d    = 1'b1;
            mem_en_d    = 1'b1;
            mem_addr_d  = if_addr;
            mem_wdata_d = '0;
            state_d     = ST_OPEN;
        end else if (lock_hold) begin
            state_d = ST_LOCKED;
        end else if (state_q == ST_LOCKED) begin
            state_d = ST_OPEN;
        end
    end

    always_ff @(posedge clk or negedge Rst) begin
        if (!Rst) begin
            state_q     <= ST_IDLE;
            if_ack_q    <= 1'b0;
            ls_ack_q    <= 1'b0;
            if_rvalid_q <= 1'b0;
            ls_rvalid_q <= 1'b0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            if_ack_q    <= if_ack_d;
            ls_ack_q    <= ls_ack_d;
            if_rvalid_q <= if_rvalid_d;
            ls_rvalid_q <= ls_rvalid_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    assign if_ack    = if_ack_q;
    assign ls_ack    = ls_ack_q;
    assign if_rvalid = if_rvalid_q;
    assign ls_rvalid = ls_rvalid_q;
    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign locked    = (state_q == ST_LOCKED);
    assign if_rdata  = mem_rdata;
    assign ls_rdata  = mem_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed vector table, reset-abort sequence,
// then random traffic checked against a transaction-level model with a shadow RAM.
module tb_mem_port_arbiter;

    logic        clk;
    logic        Rst;
    logic        if_req;
    logic [5:0]  if_addr;
    logic        if_ack;
    logic        if_rvalid;
    logic [31:0] if_rdata;
    logic        ls_req;
    logic        ls_we;
    logic [5:0]  ls_addr;
    logic [31:0] ls_wdata;
    logic        ls_lock;
    logic        ls_ack;
    logic        ls_rvalid;
    logic [31:0] ls_rdata;
    logic        mem_en;
    logic        mem_we;
    logic [5:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        locked;

    mem_port_arbiter #(.ADDR_W(6), .DATA_W(32)) dut (
        .clk(clk), .Rst(Rst),
        .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
        .ls_lock(ls_lock), .ls_ack(ls_ack), .ls_rvalid(ls_rvalid), .ls_rdata(ls_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .locked(locked)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM behind the port, plus the bench's own shadow copy of its contents.
    logic [31:0] ram    [64];
    logic [31:0] shadow [64];
    logic        init_done;

    always @(posedge clk) begin
        if (!init_done) begin
            for (int i = 0; i < 64; i++) ram[i] <= shadow[i];
        end else if (mem_en) begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            else        mem_rdata     <= ram[mem_addr];
        end
    end

    int n_tests;
    int n_fail;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    logic [6:0] ctrl;
    assign ctrl = {if_ack, ls_ack, mem_en, mem_we, locked, if_rvalid, ls_rvalid};

    typedef struct packed {
        logic        if_req;
        logic [5:0]  if_addr;
        logic        ls_req;
        logic        ls_we;
        logic [5:0]  ls_addr;
        logic [31:0] ls_wdata;
        logic        ls_lock;
        logic [6:0]  exp_ctrl;   // if_ack ls_ack mem_en mem_we locked if_rvalid ls_rvalid
        logic [5:0]  exp_addr;
        logic [31:0] exp_rdata;
    } vec_t;

    function automatic vec_t mk(input logic ir, input logic [5:0] ia, input logic lr,
                                input logic lw, input logic [5:0] la, input logic [31:0] ld,
                                input logic lk, input logic [6:0] ec, input logic [5:0] ea,
                                input logic [31:0] er);
        vec_t v;
        v.if_req = ir; v.if_addr = ia; v.ls_req = lr; v.ls_we = lw; v.ls_addr = la;
        v.ls_wdata = ld; v.ls_lock = lk; v.exp_ctrl = ec; v.exp_addr = ea; v.exp_rdata = er;
        return v;
    endfunction

    localparam int NV = 19;
    vec_t tbl [NV];

    // Reference model state: what should be on the port after the next edge.
    logic        m_if_ack, m_ls_ack, m_en, m_we, m_lock, m_if_rv, m_ls_rv;
    logic [5:0]  m_addr;
    logic [31:0] m_wdata, m_rdata;

    task automatic model_step();
        logic ls_ok, if_ok;
        // The access currently on the port completes at the coming edge.
        m_if_rv = m_if_ack;
        m_ls_rv = m_ls_ack && !m_we;
        if (m_en && !m_we) m_rdata = shadow[m_addr];
        if (m_en && m_we)  shadow[m_addr] = m_wdata;
        // Arbitration with the inputs that will be sampled at that edge.
        ls_ok = ls_req && !m_ls_ack;
        if_ok = if_req && !m_if_ack && !(m_lock && ls_lock);
        m_if_ack = 1'b0; m_ls_ack = 1'b0; m_en = 1'b0; m_we = 1'b0;
        if (ls_ok) begin
            m_ls_ack = 1'b1; m_en = 1'b1; m_we = ls_we;
            m_addr = ls_addr; m_wdata = ls_wdata; m_lock = ls_lock;
        end else begin
            if (!ls_lock) m_lock = 1'b0;
            if (if_ok) begin
                m_if_ack = 1'b1; m_en = 1'b1; m_addr = if_addr; m_wdata = '0;
            end
        end
    endtask

    initial begin
        n_tests = 0; n_fail = 0;
        init_done = 1'b0;
        Rst = 1'b0;
        if_req = 0; if_addr = 0; ls_req = 0; ls_we = 0; ls_addr = 0; ls_wdata = 0; ls_lock = 0;
        for (int i = 0; i < 64; i++) shadow[i] = $urandom;
        shadow[5] = 32'hE3A01001;
        shadow[9] = 32'h12345678;
        shadow[7] = 32'h00000777;

        tbl[0]  = mk(1,5, 0,0,0,32'h0,0,        7'b1010000, 5, 32'h0);
        tbl[1]  = mk(0,5, 0,0,0,32'h0,0,        7'b0000010, 5, 32'hE3A01001);
        tbl[2]  = mk(1,5, 1,0,9,32'h0,0,        7'b0110000, 9, 32'h0);
        tbl[3]  = mk(1,5, 0,0,9,32'h0,0,        7'b1010001, 5, 32'h12345678);
        tbl[4]  = mk(0,5, 0,0,0,32'h0,0,        7'b0000010, 5, 32'hE3A01001);
        tbl[5]  = mk(0,5, 1,1,3,32'hDEADBEEF,0, 7'b0111000, 3, 32'h0);
        tbl[6]  = mk(1,3, 0,0,3,32'hDEADBEEF,0, 7'b1010000, 3, 32'h0);
        tbl[7]  = mk(0,3, 0,0,0,32'h0,0,        7'b0000010, 3, 32'hDEADBEEF);
        tbl[8]  = mk(1,5, 1,0,7,32'h0,1,        7'b0110100, 7, 32'h0);
        tbl[9]  = mk(1,5, 0,0,7,32'h0,1,        7'b0000101, 7, 32'h00000777);
        tbl[10] = mk(1,5, 1,1,7,32'hCAFE0007,1, 7'b0111100, 7, 32'h0);
        tbl[11] = mk(1,5, 0,0,7,32'h0,0,        7'b1010000, 5, 32'h0);
        tbl[12] = mk(0,5, 0,0,0,32'h0,0,        7'b0000010, 5, 32'hE3A01001);
        tbl[13] = mk(1,5, 0,0,0,32'h0,0,        7'b1010000, 5, 32'h0);
        tbl[14] = mk(1,5, 0,0,0,32'h0,0,        7'b0000010, 5, 32'hE3A01001);
        tbl[15] = mk(1,5, 0,0,0,32'h0,0,        7'b1010000, 5, 32'h0);
        tbl[16] = mk(1,5, 0,0,0,32'h0,0,        7'b0000010, 5, 32'hE3A01001);
        tbl[17] = mk(1,5, 0,0,0,32'h0,0,        7'b1010000, 5, 32'h0);
        tbl[18] = mk(0,5, 0,0,0,32'h0,0,        7'b0000010, 5, 32'hE3A01001);

        // Reset state
        repeat (2) @(negedge clk);
        chk("reset_ctrl", 64'(ctrl), 64'h0);
        chk("reset_addr", 64'(mem_addr), 64'h0);
        chk("reset_wdata", 64'(mem_wdata), 64'h0);
        init_done = 1'b1;
        Rst = 1'b1;
        @(negedge clk);

        // Directed vectors, one row per clock
        for (int k = 0; k < NV; k++) begin
            if_req = tbl[k].if_req; if_addr = tbl[k].if_addr;
            ls_req = tbl[k].ls_req; ls_we = tbl[k].ls_we; ls_addr = tbl[k].ls_addr;
            ls_wdata = tbl[k].ls_wdata; ls_lock = tbl[k].ls_lock;
            if (tbl[k].ls_req && tbl[k].ls_we) shadow[tbl[k].ls_addr] = tbl[k].ls_wdata;
            @(posedge clk);
            @(negedge clk);
            chk($sformatf("vec%0d_ctrl", k), 64'(ctrl), 64'(tbl[k].exp_ctrl));
            chk($sformatf("vec%0d_addr", k), 64'(mem_addr), 64'(tbl[k].exp_addr));
            if (tbl[k].exp_ctrl[3])
                chk($sformatf("vec%0d_wdata", k), 64'(mem_wdata), 64'(tbl[k].ls_wdata));
            if (tbl[k].exp_ctrl[1])
                chk($sformatf("vec%0d_if_rdata", k), 64'(if_rdata), 64'(tbl[k].exp_rdata));
            if (tbl[k].exp_ctrl[0])
                chk($sformatf("vec%0d_ls_rdata", k), 64'(ls_rdata), 64'(tbl[k].exp_rdata));
        end

        // Reset during a pending fetch read
        if_req = 1; if_addr = 5; ls_req = 0; ls_lock = 0;
        @(posedge clk);
        @(negedge clk);
        chk("rstabort_ack", 64'(if_ack), 64'h1);
        Rst = 1'b0;
        if_req = 0;
        #1;
        chk("rstabort_ctrl", 64'(ctrl), 64'h0);
        chk("rstabort_addr", 64'(mem_addr), 64'h0);
        @(posedge clk);
        @(negedge clk);
        Rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            @(negedge clk);
            chk($sformatf("rstabort_quiet%0d", k), 64'(ctrl), 64'h0);
        end

        // Random traffic against the model
        m_if_ack = 0; m_ls_ack = 0; m_en = 0; m_we = 0; m_lock = 0;
        m_if_rv = 0; m_ls_rv = 0; m_addr = 0; m_wdata = 0; m_rdata = 0;
        for (int c = 0; c < 400; c++) begin
            if (if_req && if_ack)                      if_req = 0;
            else if (if_req && $urandom_range(15) == 0) if_req = 0;
            else if (!if_req && $urandom_range(2) != 0) begin
                if_req = 1; if_addr = 6'($urandom);
            end
            if (ls_req && ls_ack)                      ls_req = 0;
            else if (ls_req && $urandom_range(15) == 0) ls_req = 0;
            else if (!ls_req && $urandom_range(2) == 0) begin
                ls_req = 1; ls_we = 1'($urandom); ls_addr = 6'($urandom);
                ls_wdata = $urandom; ls_lock = ($urandom_range(3) == 0);
            end
            if (!ls_req && $urandom_range(2) == 0) ls_lock = 0;
            model_step();
            @(posedge clk);
            @(negedge clk);
            chk("rnd_ctrl", 64'(ctrl),
                64'({m_if_ack, m_ls_ack, m_en, m_we, m_lock, m_if_rv, m_ls_rv}));
            chk("rnd_addr", 64'(mem_addr), 64'(m_addr));
            if (m_we)    chk("rnd_wdata", 64'(mem_wdata), 64'(m_wdata));
            if (m_if_rv) chk("rnd_if_rdata", 64'(if_rdata), 64'(m_rdata));
            if (m_ls_rv) chk("rnd_ls_rdata", 64'(ls_rdata), 64'(m_rdata));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
